// File: rtl/pong_frame_scanner.sv
// Row-scanning pong renderer: one registered pixel row plus one-hot select per DWELL cycles, frame-coherent snapshots, score flash.
// Outputs change on the edge that loads a row (1-cycle register latency); en=0 freezes the scan, score_flash is still accepted.
module pong_frame_scanner #(
    parameter int WIDTH         = 8,
    parameter int HEIGHT        = 8,
    parameter int BIT_OF_WIDTH  = 3,
    parameter int BIT_OF_HEIGHT = 3,
    parameter int PADDLE_LEN    = 2,
    parameter int DWELL         = 1024,
    parameter int FLASH_FRAMES  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [BIT_OF_WIDTH-1:0]  player_top,
    input  logic [BIT_OF_WIDTH-1:0]  player_down,
    input  logic [BIT_OF_WIDTH-1:0]  x_pos,
    input  logic [BIT_OF_HEIGHT-1:0] y_pos,
    input  logic                     ball_en,
    input  logic                     score_flash,
    output logic [WIDTH-1:0]         row_data,
    output logic [HEIGHT-1:0]        row_sel,
    output logic [BIT_OF_HEIGHT-1:0] row_idx,
    output logic                     frame_start,
    output logic                     flash_active
);

    localparam int DW  = $clog2(DWELL);
    localparam int FCW = $clog2(2 * FLASH_FRAMES + 1);
    localparam int BW1 = BIT_OF_WIDTH + 1;

    localparam logic [DW-1:0]            LP_DMAX = DW'(DWELL - 1);
    localparam logic [BIT_OF_HEIGHT-1:0] LP_HMAX = BIT_OF_HEIGHT'(HEIGHT - 1);
    localparam logic [BW1-1:0]           LP_PMAX = BW1'(WIDTH - PADDLE_LEN);
    localparam logic [BW1-1:0]           LP_XLIM = BW1'(WIDTH);
    localparam logic [FCW-1:0]           LP_FEND = FCW'(2 * FLASH_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FLASH} state_t;

    // A paddle that would run off the right edge is blanked rather than clipped.
    function automatic logic [WIDTH-1:0] paddle_mask(input logic [BIT_OF_WIDTH-1:0] p);
        logic [WIDTH-1:0] m;
        m = '0;
        if ({1'b0, p} <= LP_PMAX) begin
            for (int i = 0; i < PADDLE_LEN; i++) m[i] = 1'b1;
        end
        return m << p;
    endfunction

    function automatic logic [WIDTH-1:0] row_pixels(
        input logic [BIT_OF_HEIGHT-1:0] row,
        input logic [BIT_OF_WIDTH-1:0]  top,
        input logic [BIT_OF_WIDTH-1:0]  down,
        input logic [BIT_OF_WIDTH-1:0]  x,
        input logic [BIT_OF_HEIGHT-1:0] y,
        input logic                     ben
    );
        logic [WIDTH-1:0] pix;
        pix = '0;
        if (row == '0)     pix = pix | paddle_mask(top);
        if (row == LP_HMAX) pix = pix | paddle_mask(down);
        if (ben && (y == row) && ({1'b0, x} < LP_XLIM)) pix = pix | (WIDTH'(1) << x);
        return pix;
    endfunction

    logic [DW-1:0]            r_dwell_cnt;
    logic [BIT_OF_HEIGHT-1:0] r_row_idx;
    logic [WIDTH-1:0]         r_row_data;
    logic [HEIGHT-1:0]        r_row_sel;
    logic                     r_frame_start;
    logic                     r_flash_active;
    state_t                   r_state;
    logic [FCW-1:0]           r_frame_cnt;
    logic [BIT_OF_WIDTH-1:0]  r_sh_top;
    logic [BIT_OF_WIDTH-1:0]  r_sh_down;
    logic [BIT_OF_WIDTH-1:0]  r_sh_x;
    logic [BIT_OF_HEIGHT-1:0] r_sh_y;
    logic                     r_sh_ben;

    logic                     w_row_end;
    logic                     w_boundary;
    logic [BIT_OF_HEIGHT-1:0] w_row_nxt;
    logic [WIDTH-1:0]         w_row_pix;
    logic [FCW-1:0]           w_cnt_inc;
    logic                     w_blank;

    assign w_row_end  = en && (r_dwell_cnt == LP_DMAX);
    assign w_boundary = w_row_end && (r_row_idx == LP_HMAX);
    assign w_row_nxt  = (r_row_idx == LP_HMAX) ? '0 : r_row_idx + 1'b1;
    assign w_cnt_inc  = r_frame_cnt + 1'b1;

    // Row 0 bypasses the shadow registers so it already reflects the snapshot being taken.
    assign w_row_pix = row_pixels(w_row_nxt,
                                  w_boundary ? player_top  : r_sh_top,
                                  w_boundary ? player_down : r_sh_down,
                                  w_boundary ? x_pos       : r_sh_x,
                                  w_boundary ? y_pos       : r_sh_y,
                                  w_boundary ? ball_en     : r_sh_ben);

    // Blanking follows the flash state that will hold after this edge.
    always_comb begin
        w_blank = 1'b0;
        case (r_state)
            S_ARMED: w_blank = w_boundary;
            S_FLASH: begin
                if (score_flash)     w_blank = 1'b0;
                else if (w_boundary) w_blank = !w_cnt_inc[0] && (w_cnt_inc != LP_FEND);
                else                 w_blank = !r_frame_cnt[0];
            end
            default: w_blank = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_cnt   <= LP_DMAX;
            r_row_idx     <= LP_HMAX;
            r_row_data    <= '0;
            r_row_sel     <= '0;
            r_frame_start <= 1'b0;
            r_sh_top      <= '0;
            r_sh_down     <= '0;
            r_sh_x        <= '0;
            r_sh_y        <= '0;
            r_sh_ben      <= 1'b0;
        end else begin
            if (w_row_end) begin
                r_dwell_cnt <= '0;
                r_row_idx   <= w_row_nxt;
                r_row_data  <= w_blank ? '0 : w_row_pix;
                r_row_sel   <= HEIGHT'(1) << w_row_nxt;
            end else if (en) begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
            r_frame_start <= w_boundary;
            if (w_boundary) begin
                r_sh_top  <= player_top;
                r_sh_down <= player_down;
                r_sh_x    <= x_pos;
                r_sh_y    <= y_pos;
                r_sh_ben  <= ball_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_frame_cnt    <= '0;
            r_flash_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (score_flash) begin
                        r_state        <= S_ARMED;
                        r_flash_active <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_boundary) begin
                        r_state     <= S_FLASH;
                        r_frame_cnt <= '0;
                    end
                end
                S_FLASH: begin
                    if (score_flash) begin
                        r_state <= S_ARMED;
                    end else if (w_boundary) begin
                        r_frame_cnt <= w_cnt_inc;
                        if (w_cnt_inc == LP_FEND) begin
                            r_state        <= S_IDLE;
                            r_flash_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_flash_active <= 1'b0;
                end
            endcase
        end
    end

    assign row_data     = r_row_data;
    assign row_sel      = r_row_sel;
    assign row_idx      = r_row_idx;
    assign frame_start  = r_frame_start;
    assign flash_active = r_flash_active;

endmodule

// File: tb/tb_pong_frame_scanner.sv
// Bench for pong_frame_scanner: two instances (paddle length 2 and 3) against a frame-level reference model.
module tb_pong_frame_scanner;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int D  = 16;
    localparam int FF = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] player_top;
    logic [2:0] player_down;
    logic [2:0] x_pos;
    logic [2:0] y_pos;
    logic       ball_en;
    logic       score_flash;

    logic [7:0] a_row_data, b_row_data;
    logic [7:0] a_row_sel, b_row_sel;
    logic [2:0] a_row_idx, b_row_idx;
    logic       a_frame_start, b_frame_start;
    logic       a_flash_active, b_flash_active;

    pong_frame_scanner #(.WIDTH(W), .HEIGHT(H), .BIT_OF_WIDTH(3), .BIT_OF_HEIGHT(3),
                         .PADDLE_LEN(2), .DWELL(D), .FLASH_FRAMES(FF)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .player_top(player_top), .player_down(player_down),
        .x_pos(x_pos), .y_pos(y_pos), .ball_en(ball_en), .score_flash(score_flash),
        .row_data(a_row_data), .row_sel(a_row_sel), .row_idx(a_row_idx),
        .frame_start(a_frame_start), .flash_active(a_flash_active)
    );

    pong_frame_scanner #(.WIDTH(W), .HEIGHT(H), .BIT_OF_WIDTH(3), .BIT_OF_HEIGHT(3),
                         .PADDLE_LEN(3), .DWELL(D), .FLASH_FRAMES(FF)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .player_top(player_top), .player_down(player_down),
        .x_pos(x_pos), .y_pos(y_pos), .ball_en(ball_en), .score_flash(score_flash),
        .row_data(b_row_data), .row_sel(b_row_sel), .row_idx(b_row_idx),
        .frame_start(b_frame_start), .flash_active(b_flash_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: scan position is pure arithmetic on the count of enabled edges,
    // flash is tracked as "mode + frame number where flashing began".
    int         m_t, m_f, m_mode, m_fstart;
    logic [2:0] s_top, s_down, s_x, s_y;
    logic       s_ben;
    logic [7:0] e_data_a, e_data_b, e_sel;
    logic [2:0] e_idx;
    logic       e_fs, e_fa;

    function automatic logic [7:0] ref_row(input int r, input int plen);
        logic [7:0] v;
        int tp, dn;
        tp = int'(s_top);
        dn = int'(s_down);
        v  = '0;
        for (int c = 0; c < W; c++) begin
            if (r == 0 && tp + plen <= W && c >= tp && c < tp + plen) v[c] = 1'b1;
            if (r == H - 1 && dn + plen <= W && c >= dn && c < dn + plen) v[c] = 1'b1;
            if (s_ben && int'(s_y) == r && int'(s_x) == c) v[c] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_t = 0; m_f = 0; m_mode = 0; m_fstart = 0;
        s_top = '0; s_down = '0; s_x = '0; s_y = '0; s_ben = 1'b0;
        e_data_a = '0; e_data_b = '0; e_sel = '0; e_idx = 3'(H - 1);
        e_fs = 1'b0; e_fa = 1'b0;
    endtask

    task automatic model_edge();
        int  prev, r;
        bit  bnd, rowedge, blank;
        bnd = 0; rowedge = 0;
        if (en) begin
            m_t++;
            rowedge = ((m_t - 1) % D) == 0;
            bnd     = ((m_t - 1) % (D * H)) == 0;
            if (bnd) begin
                m_f = (m_t - 1) / (D * H);
                s_top = player_top; s_down = player_down;
                s_x = x_pos; s_y = y_pos; s_ben = ball_en;
            end
        end
        prev = m_mode;
        if (score_flash && prev != 1) m_mode = 1;
        else if (bnd) begin
            if (prev == 1) begin
                m_mode = 2; m_fstart = m_f;
            end else if (prev == 2 && m_f - m_fstart >= 2 * FF) begin
                m_mode = 0;
            end
        end
        e_fs = bnd;
        e_fa = (m_mode != 0);
        if (rowedge) begin
            r        = ((m_t - 1) / D) % H;
            e_idx    = 3'(r);
            e_sel    = '0;
            e_sel[r] = 1'b1;
            blank    = (m_mode == 2) && (((m_f - m_fstart) % 2) == 0);
            e_data_a = blank ? 8'h00 : ref_row(r, 2);
            e_data_b = blank ? 8'h00 : ref_row(r, 3);
        end
    endtask

    task automatic compare_all();
        chk("a_data", a_row_data, e_data_a);
        chk("a_sel", a_row_sel, e_sel);
        chk("a_idx", a_row_idx, e_idx);
        chk("a_fs", a_frame_start, e_fs);
        chk("a_fa", a_flash_active, e_fa);
        chk("b_data", b_row_data, e_data_b);
        chk("b_sel", b_row_sel, e_sel);
        chk("b_idx", b_row_idx, e_idx);
        chk("b_fs", b_frame_start, e_fs);
        chk("b_fa", b_flash_active, e_fa);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run_to_boundary();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!e_fs && n < 2000);
        chk("boundary_wait", e_fs, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; score_flash = 1'b0;
        player_top = 3'd0; player_down = 3'd6; x_pos = 3'd3; y_pos = 3'd4; ball_en = 1'b1;
        model_reset();
        #12;
        compare_all();
        rst_n = 1'b1;
        en    = 1'b1;

        // Basic frame: first enabled edge loads row 0
        step();
        chk("t1_row0", a_row_data, 8'h03);
        chk("t1_fs", a_frame_start, 1);
        repeat (4 * D) step();
        chk("t1_row4", a_row_data, 8'h08);
        repeat (3 * D) step();
        chk("t1_row7", a_row_data, 8'hC0);

        // Paddle at the right edge
        player_top = 3'd7;
        run_to_boundary();
        chk("pe_a_top7", a_row_data, 8'h00);
        player_top = 3'd5;
        run_to_boundary();
        chk("pe_b_top5", b_row_data, 8'hE0);
        chk("pe_a_top5", a_row_data, 8'h60);
        player_top = 3'd6;
        run_to_boundary();
        chk("pe_b_top6", b_row_data, 8'h00);
        chk("pe_a_top6", a_row_data, 8'hC0);

        // Tear check
        player_top = 3'd0;
        run_to_boundary();
        repeat (3 * D) step();
        x_pos = 3'd5;
        repeat (D) step();
        chk("tear_old_x", a_row_data, 8'h08);
        run_to_boundary();
        repeat (4 * D) step();
        chk("tear_new_x", a_row_data, 8'h20);

        // Flash sequence, pulse in row 2
        run_to_boundary();
        repeat (2 * D + 3) step();
        score_flash = 1'b1;
        step();
        score_flash = 1'b0;
        chk("fl_active_rise", a_flash_active, 1);
        run_to_boundary();
        chk("fl_blank0", a_row_data, 8'h00);
        run_to_boundary();
        chk("fl_show1", a_row_data, 8'h03);
        repeat (4) run_to_boundary();
        chk("fl_still_active", a_flash_active, 1);
        run_to_boundary();
        chk("fl_idle_fa", a_flash_active, 0);
        chk("fl_idle_row0", a_row_data, 8'h03);

        // en low mid-row stretches the row
        run_to_boundary();
        repeat (5) step();
        en = 1'b0;
        repeat (50) step();
        en = 1'b1;
        n = 0;
        while (a_row_idx == 3'd0 && n < 500) begin
            step();
            n++;
        end
        chk("en_row_len", 32'(n + 55), 32'(D + 50));

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            player_top  = 3'($urandom_range(0, 7));
            player_down = 3'($urandom_range(0, 7));
            x_pos       = 3'($urandom_range(0, 7));
            y_pos       = 3'($urandom_range(0, 7));
            ball_en     = ($urandom_range(0, 3) != 0);
            score_flash = ($urandom_range(0, 199) == 0);
            step();
        end
        score_flash = 1'b0;
        en          = 1'b1;

        // Asynchronous reset in the middle of a flash
        run_to_boundary();
        score_flash = 1'b1;
        step();
        score_flash = 1'b0;
        run_to_boundary();
        repeat (5 * D) step();
        chk("rst_pre_fa", a_flash_active, 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_async_data", a_row_data, 8'h00);
        #3;
        rst_n = 1'b1;
        step();
        chk("rst_first_fs", a_frame_start, 1);
        chk("rst_first_idx", a_row_idx, 0);
        chk("rst_first_fa", a_flash_active, 0);
        repeat (D * H + 5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
